kws_mac_pipe: RTL
=================

// Module: kws_mac_pipe
// PURPOSE
//  Parametrised, pipelined multiply-accumulate unit for the KWS conv/FC layers.
//  Generalises the fixed 12x10 unsigned combinational multiplier: configurable widths,
//  per-operand signedness, NUM_STAGE product pipeline, group accumulation, valid/ready flow.
//  Sits between the weight/feature fetch stream and the activation/requantise stage.
// PARAMETERS
//  A_WIDTH    12  operand A (feature) width
//  B_WIDTH    10  operand B (weight) width
//  ACC_WIDTH  32  accumulator/result width; must be >= A_WIDTH+B_WIDTH
//  NUM_STAGE  2   product pipeline registers, 1..4
//  SIGNED_A   0   1: A is two's complement, 0: unsigned
//  SIGNED_B   0   1: B is two's complement, 0: unsigned
// PORTS
//  ap_clk     in   1          clock, all logic on rising edge
//  ap_rst_n   in   1          asynchronous active-low reset
//  in_valid   in   1          input beat valid
//  in_ready   out  1          unit accepts a beat this cycle
//  in_a       in   A_WIDTH    operand A
//  in_b       in   B_WIDTH    operand B
//  in_last    in   1          beat closes the current dot-product group
//  out_valid  out  1          group result valid
//  out_ready  in   1          downstream accepts result
//  out_data   out  ACC_WIDTH  accumulated group result
//  out_ovf    out  1          group over/underflowed (saturating build only)
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_ovf=0, accumulator=0, all stage valids=0;
//    in_ready=1 after reset release. Partial group in flight discarded.
//  - Advance enable en = !out_valid | out_ready; in_ready = en. Beat accepted on
//    in_valid & in_ready. When en=0 every stage, accumulator and outputs hold.
//  - Product = A*B at A_WIDTH+B_WIDTH bits, signed iff SIGNED_A|SIGNED_B (unsigned operand
//    zero-extended by 1 bit); extended (sign or zero) to ACC_WIDTH.
//  - Product valid NUM_STAGE enabled cycles after acceptance; next enabled cycle it adds
//    into accumulator. If tagged last: out_data <= acc+product, out_valid <= 1,
//    accumulator <= 0 same edge. Latency last-accept -> out_valid = NUM_STAGE+1 cycles.
//  - out_valid drops on out_valid&out_ready unless a new result loads same edge.
//  - Back-to-back groups: a beat of the next group can follow a last beat with no bubble;
//    it accumulates from 0.
//  - Beats without in_last simply accumulate; no result until a last beat arrives.
//  - in_valid with in_ready=0: beat not taken; source holds data (AXI-S rules).
// CONFIGURATION
//  KWS_MAC_SATURATE_EN defined: accumulation clamps to ACC_WIDTH max/min (signed range if
//    SIGNED_A|SIGNED_B, else 0..2^ACC_WIDTH-1); out_ovf set with the result if any add in
//    the group clamped; clamped value persists for remaining group beats.
//  Undefined: accumulation wraps modulo 2^ACC_WIDTH; out_ovf tied 0.
// TESTING
//  1 A=12,B=10 unsigned: single beat 4095*1023 last -> out_data=4189185 after NUM_STAGE+1.
//  2 4 beats a=100,b=3, last on 4th, then 1 beat a=2,b=2 last -> 1200 then 4 (acc cleared).
//  3 out_ready=0 for 5 cycles with result pending -> in_ready=0, out_data stable, no beat
//    lost or duplicated; streaming 8 groups under random out_ready matches model.
//  4 SIGNED_A=1: a=12'hFFB(-5), b=7 last -> out_data=-35 (32'hFFFFFFDD).
//  5 ACC_WIDTH=24: 5 beats 4095*1023 -> wrap 4168709, ovf=0; with KWS_MAC_SATURATE_EN
//    -> 16777215, out_ovf=1; next group ovf=0.
//  6 ap_rst_n low mid-group (2 of 4 beats in) -> outputs 0 asynchronously; new group a=1,b=1
//    last after release -> out_data=1.

Source files
------------

// File: rtl/kws_mac_pipe.sv
// kws_mac_pipe
//   Pipelined multiply-accumulate unit for the KWS conv/FC layers. It sits between
//   the weight/feature fetch stream and the activation/requantise stage. Products of
//   in_a*in_b pass through NUM_STAGE registers and are then summed into a group
//   accumulator. A beat tagged in_last closes the group and emits the sum on out_data.
//
// Ports
//   ap_clk     clock, rising edge
//   ap_rst_n   asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   unit accepts a beat this cycle
//   in_a       operand A (feature), A_WIDTH bits
//   in_b       operand B (weight), B_WIDTH bits
//   in_last    beat closes the current dot-product group
//   out_valid  group result valid
//   out_ready  downstream accepts result
//   out_data   accumulated group result, ACC_WIDTH bits
//   out_ovf    group clamped (saturating build only, else 0)
//
// Build option
//   KWS_MAC_SATURATE_EN : accumulation saturates and out_ovf is reported;
//                         when undefined the accumulator wraps and out_ovf is 0.

module kws_mac_pipe #(
    parameter int A_WIDTH   = 12,
    parameter int B_WIDTH   = 10,
    parameter int ACC_WIDTH = 32,
    parameter int NUM_STAGE = 2,
    parameter int SIGNED_A  = 0,
    parameter int SIGNED_B  = 0
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   in_a,
    input  logic [B_WIDTH-1:0]   in_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_ovf
);

    localparam int PROD_W    = A_WIDTH + B_WIDTH;
    localparam bit IS_SIGNED = (SIGNED_A != 0) || (SIGNED_B != 0);

    logic en;
    logic accept;

    // A single advance enable freezes the whole pipe while a result waits downstream.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    // Operands get one extra bit so an unsigned operand stays non-negative in a
    // signed multiply; the low PROD_W bits of the product are exact.
    logic signed [A_WIDTH:0]   a_ext;
    logic signed [B_WIDTH:0]   b_ext;
    logic signed [PROD_W-1:0]  prod;
    logic [ACC_WIDTH-1:0]      prod_ext;

    always_comb begin
        a_ext = (SIGNED_A != 0) ? $signed({in_a[A_WIDTH-1], in_a}) : $signed({1'b0, in_a});
        b_ext = (SIGNED_B != 0) ? $signed({in_b[B_WIDTH-1], in_b}) : $signed({1'b0, in_b});
        prod  = PROD_W'(a_ext) * PROD_W'(b_ext);
        if (IS_SIGNED) begin
            prod_ext = ACC_WIDTH'(prod);
        end else begin
            prod_ext = ACC_WIDTH'($unsigned(prod));
        end
    end

    // Product pipeline: stage 0 captures the accepted beat, later stages shift.
    logic [NUM_STAGE-1:0] stg_valid;
    logic [NUM_STAGE-1:0] stg_last;
    logic [ACC_WIDTH-1:0] stg_prod [NUM_STAGE];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stg_valid <= '0;
            stg_last  <= '0;
            for (int unsigned i = 0; i < NUM_STAGE; i++) begin
                stg_prod[i] <= '0;
            end
        end else if (en) begin
            stg_valid[0] <= accept;
            stg_last[0]  <= accept && in_last;
            stg_prod[0]  <= prod_ext;
            for (int unsigned i = 1; i < NUM_STAGE; i++) begin
                stg_valid[i] <= stg_valid[i-1];
                stg_last[i]  <= stg_last[i-1];
                stg_prod[i]  <= stg_prod[i-1];
            end
        end
    end

    logic                 tail_valid;
    logic                 tail_last;
    logic [ACC_WIDTH-1:0] tail_prod;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] sum;

    assign tail_valid = stg_valid[NUM_STAGE-1];
    assign tail_last  = stg_last[NUM_STAGE-1];
    assign tail_prod  = stg_prod[NUM_STAGE-1];

`ifdef KWS_MAC_SATURATE_EN
    logic                 clamp;
    logic                 acc_ovf;
    logic [ACC_WIDTH:0]   wide;

    // One guard bit detects overflow; signed mode compares guard and sign bit.
    always_comb begin
        clamp = 1'b0;
        if (IS_SIGNED) begin
            wide = {acc[ACC_WIDTH-1], acc} + {tail_prod[ACC_WIDTH-1], tail_prod};
            if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
                clamp = 1'b1;
                sum   = wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                        : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end else begin
                sum = wide[ACC_WIDTH-1:0];
            end
        end else begin
            wide  = {1'b0, acc} + {1'b0, tail_prod};
            clamp = wide[ACC_WIDTH];
            sum   = clamp ? '1 : wide[ACC_WIDTH-1:0];
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_ovf <= 1'b0;
            out_ovf <= 1'b0;
        end else if (en && tail_valid) begin
            if (tail_last) begin
                out_ovf <= acc_ovf || clamp;
                acc_ovf <= 1'b0;
            end else begin
                acc_ovf <= acc_ovf || clamp;
            end
        end
    end
`else
    always_comb begin
        sum = acc + tail_prod;
    end

    assign out_ovf = 1'b0;
`endif

    // A closing beat loads the result and restarts the accumulator at zero on the
    // same edge, so the next group's first product can follow with no bubble.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= 1'b0;
            if (tail_valid) begin
                if (tail_last) begin
                    out_data  <= sum;
                    out_valid <= 1'b1;
                    acc       <= '0;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

endmodule
